// File: rtl/data_mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// data_mem_arb_pkg
// Shared definitions for the two-master data memory arbiter:
//   - arbiter state encoding (IDLE / GNT_M0 / GNT_M1)
//   - master index constants used to index the grant vector
//   - default address, data and grant-counter widths
// ----------------------------------------------------------------------------
package data_mem_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CNT_WIDTH  = 16;

    localparam int M0 = 0;
    localparam int M1 = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_M0 = 2'd1,
        GNT_M1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/data_mem_arbiter_counter.sv
// ----------------------------------------------------------------------------
// arb_grant_counter
// Saturating up-counter with enable, used to count grants per master.
// Ports:
//   clk   - clock, rising edge
//   rstn  - asynchronous active-low reset, clears the count
//   en    - count this cycle
//   count - current count, sticks at all-ones
// ----------------------------------------------------------------------------
module arb_grant_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // The count only ever moves upward and freezes at all-ones, so a
    // long-running statistic never wraps back to a misleadingly small value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// ----------------------------------------------------------------------------
// data_mem_arbiter
// Shares the single-port data memory between the CPU (master 0) and the host
// loader/debug port (master 1). Round-robin between the masters, with a host
// lock that keeps ownership with master 1 for atomic multi-word transfers.
// A request seen in cycle T is issued on the memory in T+1 (gnt high) and,
// for reads, returned in T+2 with a one-cycle rvalid pulse.
// Optional feature macro: ARB_STATS_EN builds per-master grant counters;
// without it grant_cnt0/grant_cnt1 are tied to 0.
// Ports:
//   clk, rstn                 - clock and asynchronous active-low reset
//   m0_* / m1_*               - master command (req/we/addr/wdata), grant,
//                               read valid and read data
//   m1_lock                   - host keeps ownership while high
//   mem_addr/rd_en/wr_en/
//   mem_data_in               - registered memory command
//   mem_data_out              - memory read data, one cycle after mem_rd_en
//   grant_cnt0/grant_cnt1     - grant statistics
// ----------------------------------------------------------------------------
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    input  logic                  m1_lock,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic [CNT_WIDTH-1:0]  grant_cnt0,
    output logic [CNT_WIDTH-1:0]  grant_cnt1
);

    arb_state_t state;
    arb_state_t state_next;
    logic [1:0] win;
    logic       rr_favour_m1;
    logic       last_m1;

    // State register. The state is the registered record of which master's
    // command is currently on the memory, and it drives the grant outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arbitration on the current requests. A held lock only counts once
    // master 1 actually owns the memory (last grant was m1); while it holds,
    // master 0 is shut out even if master 1 is idle. Otherwise contention is
    // resolved by the round-robin pointer. An illegal state returns to IDLE
    // without issuing anything.
    always_comb begin
        state_next = IDLE;
        win        = '0;
        m0_gnt     = 1'b0;
        m1_gnt     = 1'b0;
        if (m1_lock && last_m1) begin
            win[M1] = m1_req;
        end else if (m0_req && m1_req) begin
            win[M1] = rr_favour_m1;
            win[M0] = !rr_favour_m1;
        end else begin
            win[M0] = m0_req;
            win[M1] = m1_req;
        end
        case (state)
            IDLE:    ;
            GNT_M0:  m0_gnt = 1'b1;
            GNT_M1:  m1_gnt = 1'b1;
            default: win = '0;
        endcase
        if (win[M0]) begin
            state_next = GNT_M0;
        end else if (win[M1]) begin
            state_next = GNT_M1;
        end
    end

    // Memory command register plus ownership history. Address and write
    // data hold their last value when idle so the memory pins stay quiet.
    // The pointer always favours whichever master was not served last.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_addr     <= '0;
            mem_data_in  <= '0;
            mem_rd_en    <= 1'b0;
            mem_wr_en    <= 1'b0;
            rr_favour_m1 <= 1'b0;
            last_m1      <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            if (win[M0]) begin
                mem_addr     <= m0_addr;
                mem_data_in  <= m0_wdata;
                mem_rd_en    <= !m0_we;
                mem_wr_en    <= m0_we;
                rr_favour_m1 <= 1'b1;
                last_m1      <= 1'b0;
            end else if (win[M1]) begin
                mem_addr     <= m1_addr;
                mem_data_in  <= m1_wdata;
                mem_rd_en    <= !m1_we;
                mem_wr_en    <= m1_we;
                rr_favour_m1 <= 1'b0;
                last_m1      <= 1'b1;
            end
        end
    end

    // Read-return tracking: a read issued this cycle comes back next cycle,
    // tagged with the master that owned the memory. Reset drops any read in
    // flight because these flags clear with everything else.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
        end else begin
            m0_rvalid <= mem_rd_en && (state == GNT_M0);
            m1_rvalid <= mem_rd_en && (state == GNT_M1);
        end
    end

    assign m0_rdata = m0_rvalid ? mem_data_out : '0;
    assign m1_rdata = m1_rvalid ? mem_data_out : '0;

`ifdef ARB_STATS_EN
    arb_grant_counter #(.WIDTH(CNT_WIDTH)) u_cnt0 (
        .clk   (clk),
        .rstn  (rstn),
        .en    (m0_gnt),
        .count (grant_cnt0)
    );

    arb_grant_counter #(.WIDTH(CNT_WIDTH)) u_cnt1 (
        .clk   (clk),
        .rstn  (rstn),
        .en    (m1_gnt),
        .count (grant_cnt1)
    );
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_data_mem_arbiter
// Directed self-checking bench for data_mem_arbiter with a small behavioural
// 8x8 data memory (synchronous read, data one cycle after mem_rd_en).
// Honours ARB_STATS_EN for the expected grant counter values.
// ----------------------------------------------------------------------------
module tb_data_mem_arbiter;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en, mem_wr_en;
    logic [DW-1:0] mem_data_in, mem_data_out;
    logic [CW-1:0] grant_cnt0, grant_cnt1;

    logic [DW-1:0] mem [0:7];
    logic          load_en = 1'b0;
    logic [DW-1:0] wd;

    int checks = 0;
    int failures = 0;
    int exp_cnt0;
    int exp_cnt1;

    data_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .m0_req       (m0_req),
        .m0_we        (m0_we),
        .m0_addr      (m0_addr),
        .m0_wdata     (m0_wdata),
        .m0_gnt       (m0_gnt),
        .m0_rvalid    (m0_rvalid),
        .m0_rdata     (m0_rdata),
        .m1_req       (m1_req),
        .m1_we        (m1_we),
        .m1_addr      (m1_addr),
        .m1_wdata     (m1_wdata),
        .m1_gnt       (m1_gnt),
        .m1_rvalid    (m1_rvalid),
        .m1_rdata     (m1_rdata),
        .m1_lock      (m1_lock),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_en    (mem_wr_en),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .grant_cnt0   (grant_cnt0),
        .grant_cnt1   (grant_cnt1)
    );

    always #5 clk = ~clk;

    // Behavioural data memory with a preload port for known contents.
    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
            mem[1] <= 8'h11;
            mem[2] <= 8'h22;
            mem[3] <= 8'h5A;
        end else begin
            if (mem_wr_en) mem[mem_addr] <= mem_data_in;
            if (mem_rd_en) mem_data_out <= mem[mem_addr];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int r0, input int w0, input int a0, input int d0,
                                 input int r1, input int w1, input int a1, input int d1,
                                 input int lk);
        m0_req   = 1'(r0);
        m0_we    = 1'(w0);
        m0_addr  = AW'(a0);
        m0_wdata = DW'(d0);
        m1_req   = 1'(r1);
        m1_we    = 1'(w1);
        m1_addr  = AW'(a1);
        m1_wdata = DW'(d1);
        m1_lock  = 1'(lk);
    endtask

    task automatic doReset;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    initial begin
`ifdef ARB_STATS_EN
        exp_cnt0 = 5;
        exp_cnt1 = 3;
`else
        exp_cnt0 = 0;
        exp_cnt1 = 0;
`endif
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rstn = 1'b0;
        load_en = 1'b1;
        tick();
        tick();
        load_en = 1'b0;

        checkOutput("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        checkOutput("rst_m1_gnt", 32'(m1_gnt), 32'd0);
        checkOutput("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        checkOutput("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        checkOutput("rst_rd_en", 32'(mem_rd_en), 32'd0);
        checkOutput("rst_wr_en", 32'(mem_wr_en), 32'd0);
        checkOutput("rst_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_wdata", 32'(mem_data_in), 32'd0);
        checkOutput("rst_m0_rdata", 32'(m0_rdata), 32'd0);
        checkOutput("rst_cnt0", 32'(grant_cnt0), 32'd0);
        checkOutput("rst_cnt1", 32'(grant_cnt1), 32'd0);
        rstn = 1'b1;
        tick();

        $display("[TB] single m0 read of addr 3");
        applyStimulus(1, 0, 3, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("t1_m0_gnt", 32'(m0_gnt), 32'd1);
        checkOutput("t1_m1_gnt", 32'(m1_gnt), 32'd0);
        checkOutput("t1_rd_en", 32'(mem_rd_en), 32'd1);
        checkOutput("t1_wr_en", 32'(mem_wr_en), 32'd0);
        checkOutput("t1_addr", 32'(mem_addr), 32'd3);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("t1_m0_rvalid", 32'(m0_rvalid), 32'd1);
        checkOutput("t1_m0_rdata", 32'(m0_rdata), 32'h5A);
        checkOutput("t1_m1_rvalid", 32'(m1_rvalid), 32'd0);
        checkOutput("t1_m1_rdata", 32'(m1_rdata), 32'd0);
        checkOutput("t1_m0_gnt_off", 32'(m0_gnt), 32'd0);
        checkOutput("t1_rd_en_off", 32'(mem_rd_en), 32'd0);
        checkOutput("t1_addr_hold", 32'(mem_addr), 32'd3);

        $display("[TB] contention after reset alternates");
        doReset();
        applyStimulus(1, 0, 1, 0, 1, 0, 2, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("t2_m0_gnt", 32'(m0_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput("t2_m1_gnt", 32'(m1_gnt), (i % 2 == 1) ? 32'd1 : 32'd0);
            checkOutput("t2_m0_rvalid", 32'(m0_rvalid), (i % 2 == 1) ? 32'd1 : 32'd0);
            checkOutput("t2_m1_rvalid", 32'(m1_rvalid), (i > 0 && i % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput("t2_m0_rdata", 32'(m0_rdata), (i % 2 == 1) ? 32'h11 : 32'd0);
            checkOutput("t2_m1_rdata", 32'(m1_rdata), (i > 0 && i % 2 == 0) ? 32'h22 : 32'd0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("t2_last_m1_rvalid", 32'(m1_rvalid), 32'd1);
        checkOutput("t2_last_m1_rdata", 32'(m1_rdata), 32'h22);
        checkOutput("t2_last_m0_rvalid", 32'(m0_rvalid), 32'd0);

        $display("[TB] m1 write then m0 read back");
        applyStimulus(0, 0, 0, 0, 1, 1, 7, 'hC3, 0);
        tick();
        checkOutput("t3_m1_gnt", 32'(m1_gnt), 32'd1);
        checkOutput("t3_wr_en", 32'(mem_wr_en), 32'd1);
        checkOutput("t3_rd_en", 32'(mem_rd_en), 32'd0);
        checkOutput("t3_addr", 32'(mem_addr), 32'd7);
        checkOutput("t3_wdata", 32'(mem_data_in), 32'hC3);
        applyStimulus(1, 0, 7, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("t3_m1_no_rvalid", 32'(m1_rvalid), 32'd0);
        checkOutput("t3_m0_gnt", 32'(m0_gnt), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("t3_m0_rvalid", 32'(m0_rvalid), 32'd1);
        checkOutput("t3_m0_rdata", 32'(m0_rdata), 32'hC3);

        $display("[TB] host lock burst of 8 writes");
        applyStimulus(1, 0, 1, 0, 1, 1, 0, 'hA0, 1);
        for (int k = 0; k < 8; k++) begin
            tick();
            checkOutput("t4_m1_gnt", 32'(m1_gnt), 32'd1);
            checkOutput("t4_m0_gnt", 32'(m0_gnt), 32'd0);
            checkOutput("t4_addr", 32'(mem_addr), 32'(k));
            checkOutput("t4_wdata", 32'(mem_data_in), 32'hA0 + 32'(k));
            if (k < 7) begin
                wd = 8'hA0 + 8'(k + 1);
                applyStimulus(1, 0, 1, 0, 1, 1, k + 1, int'(wd), 1);
            end else begin
                applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 1);
            end
        end
        tick();
        checkOutput("t4_locked_m0_gnt", 32'(m0_gnt), 32'd0);
        checkOutput("t4_locked_m1_gnt", 32'(m1_gnt), 32'd0);
        checkOutput("t4_locked_wr_en", 32'(mem_wr_en), 32'd0);
        checkOutput("t4_locked_rd_en", 32'(mem_rd_en), 32'd0);
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("t4_unlock_m0_gnt", 32'(m0_gnt), 32'd1);
        checkOutput("t4_unlock_addr", 32'(mem_addr), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("t4_m0_rdata", 32'(m0_rdata), 32'hA1);

        $display("[TB] reset during a read");
        applyStimulus(1, 0, 2, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("t5_rd_en", 32'(mem_rd_en), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("t5_async_gnt", 32'(m0_gnt), 32'd0);
        checkOutput("t5_async_rd_en", 32'(mem_rd_en), 32'd0);
        checkOutput("t5_async_addr", 32'(mem_addr), 32'd0);
        checkOutput("t5_async_wdata", 32'(mem_data_in), 32'd0);
        tick();
        checkOutput("t5_held_rvalid", 32'(m0_rvalid), 32'd0);
        rstn = 1'b1;
        tick();
        checkOutput("t5_post_m0_rvalid", 32'(m0_rvalid), 32'd0);
        checkOutput("t5_post_m1_rvalid", 32'(m1_rvalid), 32'd0);
        checkOutput("t5_post_m0_rdata", 32'(m0_rdata), 32'd0);
        applyStimulus(1, 0, 4, 0, 1, 0, 5, 0, 0);
        tick();
        checkOutput("t5_m0_first", 32'(m0_gnt), 32'd1);
        checkOutput("t5_m1_wait", 32'(m1_gnt), 32'd0);
        checkOutput("t5_addr", 32'(mem_addr), 32'd4);
        applyStimulus(0, 0, 0, 0, 1, 0, 5, 0, 0);
        tick();
        checkOutput("t5_m1_gnt", 32'(m1_gnt), 32'd1);
        checkOutput("t5_m0_rdata", 32'(m0_rdata), 32'hA4);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("t5_m1_rvalid", 32'(m1_rvalid), 32'd1);
        checkOutput("t5_m1_rdata", 32'(m1_rdata), 32'hA5);

        $display("[TB] grant statistics 5 m0 / 3 m1");
        doReset();
        applyStimulus(1, 0, 0, 0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("t6_m0_gnt", 32'(m0_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("t6_m0_solo_a", 32'(m0_gnt), 32'd1);
        tick();
        checkOutput("t6_m0_solo_b", 32'(m0_gnt), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("t6_cnt0", 32'(grant_cnt0), 32'(exp_cnt0));
        checkOutput("t6_cnt1", 32'(grant_cnt1), 32'(exp_cnt1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
